maze_mem_arbiter: RTL and testbench

MAZE_MEM_ARBITER -- requirements
Module: maze_mem_arbiter

---
 rtl/maze_pkg.sv | 15 +
 rtl/maze_mem_arbiter_rr_pick3.sv | 35 +++
 rtl/maze_mem_arbiter.sv | 99 +++++++++
 tb/tb_maze_mem_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// maze_pkg: shared constants for the maze map memory arbiter.
//   REQ_*   requester IDs (bit positions in req/gnt/rvalid)
//   ADDR_W  map address width, {y[3:0], x[3:0]} over 16x16 cells
//   ARB/HOLD arbiter state encodings
package maze_pkg;
  localparam int ADDR_W  = 8;
  localparam int NUM_REQ = 3;

  localparam logic [1:0] REQ_LOADER = 2'd0;
  localparam logic [1:0] REQ_SOLVER = 2'd1;
  localparam logic [1:0] REQ_READER = 2'd2;

  localparam logic [0:0] ARB  = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;
endpackage

// File: rtl/maze_mem_arbiter_rr_pick3.sv
// rr_pick3: combinational 3-way round-robin picker.
//   req    in  3  requests
//   ptr    in  2  highest-priority index (0..2)
//   excl   in  3  requesters masked out of this pick
//   gnt    out 3  one-hot winner (0 when nobody eligible)
//   winner out 2  winner index (0 when nobody eligible)
module rr_pick3 (
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  input  logic [2:0] excl,
  output logic [2:0] gnt,
  output logic [1:0] winner
);
  logic [2:0] cand;
  logic [2:0] sum;
  logic [1:0] idx;

  // Walk from the farthest slot back to ptr so the nearest eligible
  // requester is the last assignment and therefore wins.
  always_comb begin
    cand   = req & ~excl;
    gnt    = '0;
    winner = '0;
    sum    = '0;
    idx    = '0;
    for (int k = 2; k >= 0; k--) begin
      sum = {1'b0, ptr} + 3'(k);
      idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
      if (cand[idx]) begin
        gnt    = 3'b001 << idx;
        winner = idx;
      end
    end
  end
endmodule

// File: rtl/maze_mem_arbiter.sv
// maze_mem_arbiter: round-robin arbiter with burst lock in front of the
// single-port maze map memory (loader, solver, path reader).
//   clk/rst             clock, synchronous active-high reset
//   req/we/addr_in/
//   wdata_in/lock       per-requester command and burst-hold request
//   gnt                 one-hot accept, same cycle as the memory command
//   rvalid/rdata        read return one cycle after a read grant
//   mem_addr/mem_we/
//   mem_wdata/mem_rdata external map memory port
//   busy                high while a lock hold is in effect this cycle
module maze_mem_arbiter #(
  parameter int ADDR_W   = maze_pkg::ADDR_W,
  parameter int LOCK_MAX = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0]             req,
  input  logic [2:0]             we,
  input  logic [2:0][ADDR_W-1:0] addr_in,
  input  logic [2:0]             wdata_in,
  input  logic [2:0]             lock,
  output logic [2:0]             gnt,
  output logic [2:0]             rvalid,
  output logic                   rdata,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic                   mem_we,
  output logic                   mem_wdata,
  input  logic                   mem_rdata,
  output logic                   busy
);
  import maze_pkg::*;

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  logic [0:0]        state;
  logic [1:0]        ptr, owner, win, pick_win;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        rv_pipe, pick_gnt, excl;
  logic              own_keep, hold_cont, any_gnt;

  // Owner still wants the bus; hold continues only below the burst limit.
  assign own_keep  = req[owner] & lock[owner];
  assign hold_cont = (state == HOLD) && own_keep && (cnt < CNT_W'(LOCK_MAX));

  // Voluntary release: owner sits out this cycle's pick. On a forced
  // release (cnt at limit) ptr is already owner+1, so the owner naturally
  // lands at lowest priority and may still win if alone.
  assign excl = ((state == HOLD) && !own_keep) ? (3'b001 << owner) : 3'b000;

  rr_pick3 u_pick (
    .req    (req),
    .ptr    (ptr),
    .excl   (excl),
    .gnt    (pick_gnt),
    .winner (pick_win)
  );

  always_comb begin
    gnt = hold_cont ? (3'b001 << owner) : pick_gnt;
    win = hold_cont ? owner : pick_win;
    if (rst) gnt = '0;
  end

  assign any_gnt   = |gnt;
  assign mem_addr  = any_gnt ? addr_in[win] : addr_q;
  assign mem_we    = any_gnt & we[win];
  assign mem_wdata = any_gnt & wdata_in[win];
  assign busy      = hold_cont & ~rst;
  // Gate with rst so a read granted just before reset never surfaces.
  assign rvalid    = rst ? 3'b000 : rv_pipe;
  assign rdata     = (|rvalid) & mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ARB;
      ptr     <= '0;
      cnt     <= '0;
      owner   <= '0;
      rv_pipe <= '0;
      addr_q  <= '0;
    end else begin
      rv_pipe <= (any_gnt && !we[win]) ? gnt : 3'b000;
      if (any_gnt) begin
        addr_q <= addr_in[win];
        ptr    <= (win == 2'd2) ? 2'd0 : win + 2'd1;
        if (lock[win]) begin
          state <= HOLD;
          owner <= win;
          cnt   <= hold_cont ? cnt + CNT_W'(1) : CNT_W'(1);
        end else begin
          state <= ARB;
        end
      end else begin
        state <= ARB;
      end
    end
  end
endmodule

// File: tb/tb_maze_mem_arbiter.sv
// tb_maze_mem_arbiter: directed scenarios plus randomized traffic, all
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_maze_mem_arbiter;
  localparam int AW = 8;
  localparam int LM = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [2:0]      req = '0, we = '0, wdata_in = '0, lock = '0;
  logic [3*AW-1:0] addr_in = '0;
  logic [2:0]      gnt, rvalid;
  logic            rdata, mem_we, mem_wdata, mem_rdata, busy;
  logic [AW-1:0]   mem_addr;

  always #5 clk = ~clk;

  maze_mem_arbiter #(.ADDR_W(AW), .LOCK_MAX(LM)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr_in(addr_in),
    .wdata_in(wdata_in), .lock(lock), .gnt(gnt), .rvalid(rvalid),
    .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  // External map memory: synchronous write, read data one cycle after address.
  logic [255:0]  mem  = '0;
  logic [AW-1:0] rd_q = '0;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    rd_q <= mem_addr;
  end
  assign mem_rdata = mem[rd_q];

  // Reference model state
  bit            m_hold;
  int            m_ptr, m_owner, m_cnt;
  bit [2:0]      m_rv;
  bit            m_rd;
  bit [AW-1:0]   m_last;
  bit [255:0]    ref_mem = '0;
  int            wt [3];

  int n_cmp = 0, n_err = 0;
  logic [2:0] obs_gnt;
  logic       obs_busy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3*AW-1:0] pk(input logic [AW-1:0] a0, a1, a2);
    return {a2, a1, a0};
  endfunction

  // One clock cycle: apply inputs, check DUT against the model, advance the model.
  task automatic step(input bit r, input logic [2:0] rq, w, input logic [3*AW-1:0] a,
                      input logic [2:0] wd, lk);
    int win, base, cand;
    bit cont, keep, skip;
    bit [2:0] e_g;
    bit [AW-1:0] e_addr;
    @(posedge clk);
    #2;
    rst = r; req = rq; we = w; addr_in = a; wdata_in = wd; lock = lk;
    #2;
    obs_gnt  = gnt;
    obs_busy = busy;
    if (r) begin
      chk("rst_gnt", gnt, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_busy", busy, 0);
      m_hold = 0; m_ptr = 0; m_owner = 0; m_cnt = 0; m_rv = 0; m_last = 0;
      for (int i = 0; i < 3; i++) wt[i] = 0;
      return;
    end
    chk("rvalid", rvalid, m_rv);
    if (m_rv != 0) chk("rdata", rdata, m_rd);
    keep = m_hold && rq[m_owner] && lk[m_owner];
    cont = keep && (m_cnt < LM);
    chk("busy", busy, cont);
    win = -1;
    if (cont) win = m_owner;
    else begin
      // forced release: owner last; voluntary release: owner skipped
      base = keep ? (m_owner + 1) % 3 : m_ptr;
      for (int k = 0; k < 3; k++) begin
        cand = (base + k) % 3;
        skip = m_hold && !keep && (cand == m_owner);
        if (win < 0 && rq[cand] && !skip) win = cand;
      end
    end
    e_g = (win >= 0) ? (3'b001 << win) : 3'b000;
    chk("gnt", gnt, e_g);
    if (win >= 0) begin
      e_addr = a[win*AW +: AW];
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_we", mem_we, w[win]);
      if (w[win]) chk("mem_wdata", mem_wdata, wd[win]);
    end else begin
      chk("idle_addr", mem_addr, m_last);
      chk("idle_we", mem_we, 0);
    end
    for (int i = 0; i < 3; i++) begin
      if (!rq[i]) wt[i] = 0;
      else if (e_g[i]) begin
        chk("wait_bound", wt[i] < 2*LM + 2, 1);
        wt[i] = 0;
      end else wt[i]++;
    end
    m_rv = 0;
    if (win >= 0) begin
      m_last = e_addr;
      m_ptr  = (win + 1) % 3;
      if (w[win]) ref_mem[e_addr] = wd[win];
      else begin m_rv = e_g; m_rd = ref_mem[e_addr]; end
      if (lk[win]) begin
        if (cont) m_cnt++;
        else begin m_hold = 1; m_owner = win; m_cnt = 1; end
      end else m_hold = 0;
    end else m_hold = 0;
  endtask

  task automatic idle();
    step(0, 3'b000, 3'b000, '0, 3'b000, 3'b000);
  endtask

  task automatic do_rst();
    step(1, 3'b000, 3'b000, '0, 3'b000, 3'b000);
  endtask

  logic [2:0] p_req, p_we, p_wd, p_lk;
  logic [AW-1:0] p_a [3];
  logic [2:0] seq [4];

  initial begin
    // Round-robin rotation with all requesting, no lock
    do_rst();
    seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100; seq[3] = 3'b001;
    for (int i = 0; i < 4; i++) begin
      step(0, 3'b111, 3'b000, pk(8'h01, 8'h02, 8'h03), 3'b000, 3'b000);
      chk("rr_seq", obs_gnt, seq[i]);
    end
    idle();

    // Solver read of 0x23 after the loader writes a wall there
    do_rst();
    step(0, 3'b001, 3'b001, pk(8'h23, 8'h00, 8'h00), 3'b001, 3'b000);
    step(0, 3'b010, 3'b000, pk(8'h00, 8'h23, 8'h00), 3'b000, 3'b000);
    chk("rd_gnt", obs_gnt, 3'b010);
    idle();
    chk("rd_rvalid", rvalid, 3'b010);
    chk("rd_data", rdata, 1'b1);
    idle();
    chk("rd_once", rvalid, 3'b000);

    // Loader lock with reader waiting: 8 loader grants then reader
    do_rst();
    for (int i = 0; i < 9; i++) begin
      step(0, 3'b101, 3'b111, pk(8'h10, 8'h00, 8'h44), 3'b001, 3'b001);
      if (i < 8) chk("lock_own", obs_gnt, 3'b001);
      else       chk("lock_rel", obs_gnt, 3'b100);
      if (i >= 1 && i < 8) chk("lock_busy", obs_busy, 1'b1);
    end
    idle();

    // Loader lock alone for 12 cycles: continuous grant, re-lock after limit
    do_rst();
    for (int i = 0; i < 12; i++) begin
      step(0, 3'b001, 3'b001, pk(8'(i), 8'h00, 8'h00), 3'b001, 3'b001);
      chk("solo_gnt", obs_gnt, 3'b001);
    end
    idle();

    // Owner drops lock while solver requests: solver granted same cycle
    do_rst();
    step(0, 3'b011, 3'b000, pk(8'h05, 8'h06, 8'h00), 3'b000, 3'b001);
    step(0, 3'b011, 3'b000, pk(8'h05, 8'h06, 8'h00), 3'b000, 3'b000);
    chk("drop_gnt", obs_gnt, 3'b010);
    chk("drop_busy", obs_busy, 1'b0);
    idle();

    // Reset one cycle after a read grant drops the read
    do_rst();
    step(0, 3'b010, 3'b000, pk(8'h00, 8'h23, 8'h00), 3'b000, 3'b000);
    do_rst();
    idle();
    chk("rst_drop", rvalid, 3'b000);
    step(0, 3'b100, 3'b000, pk(8'h00, 8'h00, 8'h07), 3'b000, 3'b000);
    chk("post_rst", obs_gnt, 3'b100);
    step(0, 3'b011, 3'b000, pk(8'h01, 8'h02, 8'h00), 3'b000, 3'b000);
    chk("post_ptr", obs_gnt, 3'b001);

    // Randomized traffic: requests held stable until granted
    do_rst();
    p_req = '0; p_lk = '0; p_we = '0; p_wd = '0;
    for (int i = 0; i < 3; i++) p_a[i] = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!p_req[i] || obs_gnt[i]) begin
          p_req[i] = ($urandom_range(0, 99) < 60);
          p_we[i]  = 1'($urandom);
          p_wd[i]  = 1'($urandom);
          p_a[i]   = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
        end
        if ($urandom_range(0, 99) < 15) p_lk[i] = ~p_lk[i];
      end
      step(($urandom_range(0, 99) == 0), p_req, p_we, pk(p_a[0], p_a[1], p_a[2]),
           p_wd, p_lk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
